// File: rtl/decode_stage_pipe.sv
// Pipelined ID stage: decodes the 16-bit ISA into the ID/EX register.
// Adds a stall/flush handshake, load-use bubble insertion and halt drain.
module decode_stage_pipe #(
    parameter int DATA_W       = 16,
    parameter int REG_AW       = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int RED_EN       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr_in,
    input  logic              instr_valid,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              id_valid,
    output logic [8:0]        id_ctrl,
    output logic [2:0]        id_alu_op,
    output logic [REG_AW-1:0] id_rd,
    output logic [REG_AW-1:0] id_rs,
    output logic [REG_AW-1:0] id_rt,
    output logic [2:0]        id_cond,
    output logic [DATA_W-1:0] id_imm,
    output logic              stall_fetch,
    output logic              halted
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [3:0] DC      = 4'(DRAIN_CYCLES);

    logic [3:0]        w_op;
    logic [8:0]        w_ctrl;
    logic [2:0]        w_alu;
    logic [REG_AW-1:0] w_rd, w_rs, w_rt;
    logic [2:0]        w_cond;
    logic [DATA_W-1:0] w_imm;
    logic              w_use_rs, w_use_rt;
    logic              w_hazard, w_load, w_is_hlt;

    logic              r_valid;
    logic [8:0]        r_ctrl;
    logic [2:0]        r_alu;
    logic [REG_AW-1:0] r_rd, r_rs, r_rt;
    logic [2:0]        r_cond;
    logic [DATA_W-1:0] r_imm;

    logic              w_nx_valid;
    logic [8:0]        w_nx_ctrl;
    logic [2:0]        w_nx_alu;
    logic [REG_AW-1:0] w_nx_rd, w_nx_rs, w_nx_rt;
    logic [2:0]        w_nx_cond;
    logic [DATA_W-1:0] w_nx_imm;

    logic [1:0]        r_state, w_state_nx;
    logic [3:0]        r_cnt, w_cnt_nx;
    logic              r_halted;

    assign w_op = instr_in[15:12];

    // Combinational decode of the incoming instruction
    always_comb begin
        w_ctrl   = '0;
        w_alu    = '0;
        w_rd     = '0;
        w_rs     = '0;
        w_rt     = '0;
        w_cond   = '0;
        w_imm    = '0;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        if (instr_in != 16'h0000) begin
            w_cond = instr_in[11:9];
            unique case (w_op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
                    if (w_op != 4'h3 || RED_EN != 0) begin
                        w_ctrl   = 9'h001;
                        w_alu    = w_op[2:0];
                        w_rd     = REG_AW'(instr_in[11:8]);
                        w_rs     = REG_AW'(instr_in[7:4]);
                        w_rt     = REG_AW'(instr_in[3:0]);
                        w_use_rs = 1'b1;
                        w_use_rt = 1'b1;
                    end
                end
                4'h4, 4'h5, 4'h6: begin
                    w_ctrl   = 9'h003;
                    w_alu    = w_op[2:0];
                    w_rd     = REG_AW'(instr_in[11:8]);
                    w_rs     = REG_AW'(instr_in[7:4]);
                    w_imm    = DATA_W'(instr_in[3:0]);
                    w_use_rs = 1'b1;
                end
                4'h8: begin
                    w_ctrl   = 9'h01B;
                    w_rd     = REG_AW'(instr_in[11:8]);
                    w_rs     = REG_AW'(instr_in[7:4]);
                    w_imm    = {{(DATA_W-4){instr_in[3]}}, instr_in[3:0]};
                    w_use_rs = 1'b1;
                end
                4'h9: begin
                    w_ctrl   = 9'h006;
                    w_rs     = REG_AW'(instr_in[7:4]);
                    w_rt     = REG_AW'(instr_in[11:8]);
                    w_imm    = {{(DATA_W-4){instr_in[3]}}, instr_in[3:0]};
                    w_use_rs = 1'b1;
                    w_use_rt = 1'b1;
                end
                4'hA: begin
                    w_ctrl   = 9'h003;
                    w_rd     = REG_AW'(instr_in[11:8]);
                    w_rs     = REG_AW'(instr_in[11:8]);
                    w_imm    = DATA_W'(instr_in[7:0]);
                    w_use_rs = 1'b1;
                end
                4'hB: begin
                    w_ctrl = 9'h003;
                    w_rd   = REG_AW'(instr_in[11:8]);
                    w_imm  = DATA_W'(instr_in[7:0]);
                end
                4'hC: begin
                    w_ctrl = 9'h020;
                    w_imm  = {{(DATA_W-10){instr_in[8]}}, instr_in[8:0], 1'b0};
                end
                4'hD: begin
                    w_ctrl   = 9'h060;
                    w_rs     = REG_AW'(instr_in[7:4]);
                    w_use_rs = 1'b1;
                end
                4'hE: begin
                    w_ctrl = 9'h083;
                    w_rd   = REG_AW'(instr_in[11:8]);
                end
                4'hF: begin
                    w_ctrl = 9'h100;
                end
                default: ;
            endcase
        end
    end

    // Load-use detect and the capture qualifier for a real instruction
    always_comb begin
        w_hazard = r_valid && r_ctrl[4] && (r_rd != '0) && instr_valid
                && ((w_use_rs && (w_rs == r_rd))
                ||  (w_use_rt && (w_rt == r_rd)));
        w_load   = !flush && !ex_stall && !w_hazard
                && (r_state == S_RUN) && instr_valid;
        w_is_hlt = (w_op == 4'hF);
    end

    // ID register next value: flush > ex_stall > hazard/drain > load
    always_comb begin
        w_nx_valid = 1'b0;
        w_nx_ctrl  = '0;
        w_nx_alu   = '0;
        w_nx_rd    = '0;
        w_nx_rs    = '0;
        w_nx_rt    = '0;
        w_nx_cond  = '0;
        w_nx_imm   = '0;
        if (!flush && ex_stall) begin
            w_nx_valid = r_valid;
            w_nx_ctrl  = r_ctrl;
            w_nx_alu   = r_alu;
            w_nx_rd    = r_rd;
            w_nx_rs    = r_rs;
            w_nx_rt    = r_rt;
            w_nx_cond  = r_cond;
            w_nx_imm   = r_imm;
        end else if (w_load) begin
            w_nx_valid = 1'b1;
            w_nx_ctrl  = w_ctrl;
            w_nx_alu   = w_alu;
            w_nx_rd    = w_rd;
            w_nx_rs    = w_rs;
            w_nx_rt    = w_rt;
            w_nx_cond  = w_cond;
            w_nx_imm   = w_imm;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_alu   <= '0;
            r_rd    <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_cond  <= '0;
            r_imm   <= '0;
        end else begin
            r_valid <= w_nx_valid;
            r_ctrl  <= w_nx_ctrl;
            r_alu   <= w_nx_alu;
            r_rd    <= w_nx_rd;
            r_rs    <= w_nx_rs;
            r_rt    <= w_nx_rt;
            r_cond  <= w_nx_cond;
            r_imm   <= w_nx_imm;
        end
    end

    // Halt FSM state, drain counter and sticky halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_halted <= (w_state_nx == S_HALT);
        end
    end

    // Halt FSM next state; an early flush squashes the HLT still in ID
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            S_RUN: begin
                if (w_load && w_is_hlt) begin
                    w_state_nx = S_DRAIN;
                    w_cnt_nx   = DC;
                end
            end
            S_DRAIN: begin
                if (flush && (r_cnt == DC)) begin
                    w_state_nx = S_RUN;
                    w_cnt_nx   = '0;
                end else if (!ex_stall) begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nx = S_HALT;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt - 4'd1;
                    end
                end
            end
            S_HALT: begin
                w_state_nx = S_HALT;
            end
            default: begin
                w_state_nx = S_RUN;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Outputs: fetch stall and registered fields
    always_comb begin
        stall_fetch = w_hazard || ex_stall || (r_state != S_RUN);
        halted      = r_halted;
        id_valid    = r_valid;
        id_ctrl     = r_ctrl;
        id_alu_op   = r_alu;
        id_rd       = r_rd;
        id_rs       = r_rs;
        id_rt       = r_rt;
        id_cond     = r_cond;
        id_imm      = r_imm;
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: decode table plus hazard/flush/halt
// sequences, with a one-deep scoreboard of expected ID contents.
module tb_decode_stage_pipe;

    typedef struct packed {
        logic        v;
        logic [8:0]  ctrl;
        logic [2:0]  alu;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [2:0]  cond;
        logic [15:0] imm;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic        vld;
        exp_t        e;
    } vec_t;

    logic        clk, rst_n;
    logic [15:0] instr_in;
    logic        instr_valid, flush, ex_stall;
    logic        id_valid;
    logic [8:0]  id_ctrl;
    logic [2:0]  id_alu_op;
    logic [3:0]  id_rd, id_rs, id_rt;
    logic [2:0]  id_cond;
    logic [15:0] id_imm;
    logic        stall_fetch, halted;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sbq[$];
    vec_t vt[19];
    exp_t bub;

    decode_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .instr_in(instr_in), .instr_valid(instr_valid),
        .flush(flush), .ex_stall(ex_stall),
        .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_alu_op(id_alu_op), .id_rd(id_rd),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_cond(id_cond), .id_imm(id_imm),
        .stall_fetch(stall_fetch), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic exp_t mk(
        input logic [8:0] c, input logic [2:0] a,
        input logic [3:0] d, input logic [3:0] s,
        input logic [3:0] t, input logic [2:0] cd,
        input logic [15:0] im);
        exp_t e;
        e = '{v: 1'b1, ctrl: c, alu: a, rd: d, rs: s,
              rt: t, cond: cd, imm: im};
        return e;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [15:0] ins, input logic v);
        instr_in    = ins;
        instr_valid = v;
    endtask

    // push expectation, clock once, pop and compare the ID register
    task automatic cyc(input string nm, input exp_t e);
        exp_t a, x;
        sbq.push_back(e);
        step();
        a = {id_valid, id_ctrl, id_alu_op, id_rd,
             id_rs, id_rt, id_cond, id_imm};
        if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL %s: got empty queue want entry", nm);
        end else begin
            x = sbq.pop_front();
            chk(nm, 64'(a), 64'(x));
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, 64'({id_valid, id_ctrl, id_alu_op, id_rd, id_rs,
                     id_rt, id_cond, id_imm, stall_fetch, halted}),
            64'd0);
    endtask

    task automatic do_reset();
        drv(16'h0, 1'b0);
        flush = 0;
        ex_stall = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    initial begin
        clk = 0; rst_n = 0;
        instr_in = 0; instr_valid = 0;
        flush = 0; ex_stall = 0;
        bub = '0;

        vt[0]  = '{16'h0123, 1, mk(9'h001,3'd0,4'h1,4'h2,4'h3,3'd0,16'h0000)};
        vt[1]  = '{16'h0000, 1, mk(9'h000,3'd0,4'h0,4'h0,4'h0,3'd0,16'h0000)};
        vt[2]  = '{16'h1ABC, 1, mk(9'h001,3'd1,4'hA,4'hB,4'hC,3'd5,16'h0000)};
        vt[3]  = '{16'h4349, 1, mk(9'h003,3'd4,4'h3,4'h4,4'h0,3'd1,16'h0009)};
        vt[4]  = '{16'h6F1F, 1, mk(9'h003,3'd6,4'hF,4'h1,4'h0,3'd7,16'h000F)};
        vt[5]  = '{16'h845F, 1, mk(9'h01B,3'd0,4'h4,4'h5,4'h0,3'd2,16'hFFFF)};
        vt[6]  = '{16'h9A37, 1, mk(9'h006,3'd0,4'h0,4'h3,4'hA,3'd5,16'h0007)};
        vt[7]  = '{16'hA2F0, 1, mk(9'h003,3'd0,4'h2,4'h2,4'h0,3'd1,16'h00F0)};
        vt[8]  = '{16'hB780, 1, mk(9'h003,3'd0,4'h7,4'h0,4'h0,3'd3,16'h0080)};
        vt[9]  = '{16'hC5FF, 1, mk(9'h020,3'd0,4'h0,4'h0,4'h0,3'd2,16'hFFFE)};
        vt[10] = '{16'hD0A0, 1, mk(9'h060,3'd0,4'h0,4'hA,4'h0,3'd0,16'h0000)};
        vt[11] = '{16'hE900, 1, mk(9'h083,3'd0,4'h9,4'h0,4'h0,3'd4,16'h0000)};
        vt[12] = '{16'h2456, 1, mk(9'h001,3'd2,4'h4,4'h5,4'h6,3'd2,16'h0000)};
        vt[13] = '{16'h3111, 1, mk(9'h001,3'd3,4'h1,4'h1,4'h1,3'd0,16'h0000)};
        vt[14] = '{16'h7FFF, 1, mk(9'h001,3'd7,4'hF,4'hF,4'hF,3'd7,16'h0000)};
        vt[15] = '{16'h5208, 1, mk(9'h003,3'd5,4'h2,4'h0,4'h0,3'd1,16'h0008)};
        vt[16] = '{16'h0123, 0, '0};
        vt[17] = '{16'hC0FF, 1, mk(9'h020,3'd0,4'h0,4'h0,4'h0,3'd0,16'h01FE)};
        vt[18] = '{16'h8127, 1, mk(9'h01B,3'd0,4'h1,4'h2,4'h0,3'd0,16'h0007)};

        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1;
        step();

        foreach (vt[i]) begin
            drv(vt[i].instr, vt[i].vld);
            cyc($sformatf("vec%0d", i), vt[i].e);
        end
        drv(16'h0, 0);
        cyc("idle", bub);

        // load-use via rs, then rd=0, then via rt
        drv(16'h845F, 1);
        cyc("lu_lw", vt[5].e);
        drv(16'h0647, 1);
        #1 chk("lu_stall", 64'(stall_fetch), 64'd1);
        cyc("lu_bubble", bub);
        chk("lu_release", 64'(stall_fetch), 64'd0);
        cyc("lu_add", mk(9'h001,3'd0,4'h6,4'h4,4'h7,3'd3,16'h0000));
        drv(16'h805F, 1);
        cyc("lu_lw_r0", mk(9'h01B,3'd0,4'h0,4'h5,4'h0,3'd0,16'hFFFF));
        drv(16'h0607, 1);
        #1 chk("lu_r0_nostall", 64'(stall_fetch), 64'd0);
        cyc("lu_r0_add", mk(9'h001,3'd0,4'h6,4'h0,4'h7,3'd3,16'h0000));
        drv(16'h845F, 1);
        cyc("lu_lw2", vt[5].e);
        drv(16'h9410, 1);
        #1 chk("lu_rt_stall", 64'(stall_fetch), 64'd1);
        cyc("lu_rt_bubble", bub);
        cyc("lu_sw", mk(9'h006,3'd0,4'h0,4'h1,4'h4,3'd2,16'h0000));

        // ex_stall hold, then flush beating ex_stall
        drv(16'h0123, 1);
        cyc("st_add", vt[0].e);
        drv(16'h1ABC, 1);
        ex_stall = 1;
        #1 chk("st_stall", 64'(stall_fetch), 64'd1);
        cyc("st_hold", vt[0].e);
        ex_stall = 0;
        cyc("st_sub", vt[2].e);
        drv(16'h0123, 1);
        flush = 1;
        ex_stall = 1;
        cyc("fl_stall_bub", bub);
        flush = 0;
        ex_stall = 0;

        // halt drain, no stalls: halted at N+3
        drv(16'hF000, 1);
        cyc("h_hlt", mk(9'h100,3'd0,4'h0,4'h0,4'h0,3'd0,16'h0000));
        chk("h_stallN", 64'({stall_fetch, halted}), 64'b10);
        drv(16'h0123, 1);
        cyc("h_d1", bub);
        chk("h_n1", 64'(halted), 64'd0);
        cyc("h_d2", bub);
        chk("h_n2", 64'(halted), 64'd0);
        cyc("h_d3", bub);
        chk("h_n3", 64'({stall_fetch, halted}), 64'b11);
        cyc("h_after", bub);
        chk("h_sticky", 64'(halted), 64'd1);

        // halt drain with two ex_stall cycles: halted at N+5
        do_reset();
        chk_zero("rst2");
        drv(16'hF000, 1);
        cyc("hs_hlt", mk(9'h100,3'd0,4'h0,4'h0,4'h0,3'd0,16'h0000));
        drv(16'h0, 0);
        ex_stall = 1;
        cyc("hs_hold1", mk(9'h100,3'd0,4'h0,4'h0,4'h0,3'd0,16'h0000));
        cyc("hs_hold2", mk(9'h100,3'd0,4'h0,4'h0,4'h0,3'd0,16'h0000));
        ex_stall = 0;
        cyc("hs_d3", bub);
        cyc("hs_d4", bub);
        chk("hs_n4", 64'(halted), 64'd0);
        cyc("hs_d5", bub);
        chk("hs_n5", 64'(halted), 64'd1);

        // flush while HLT still in ID: back to RUN
        do_reset();
        drv(16'hF000, 1);
        cyc("fh_hlt", mk(9'h100,3'd0,4'h0,4'h0,4'h0,3'd0,16'h0000));
        drv(16'h0123, 1);
        flush = 1;
        cyc("fh_bub", bub);
        flush = 0;
        drv(16'h0, 0);
        #1 chk("fh_run", 64'({stall_fetch, halted}), 64'b00);
        drv(16'h0123, 1);
        cyc("fh_add", vt[0].e);

        // late flush in drain is ignored
        drv(16'hF000, 1);
        cyc("lf_hlt", mk(9'h100,3'd0,4'h0,4'h0,4'h0,3'd0,16'h0000));
        drv(16'h0, 0);
        cyc("lf_d1", bub);
        flush = 1;
        cyc("lf_d2", bub);
        flush = 0;
        chk("lf_stall", 64'({stall_fetch, halted}), 64'b10);
        cyc("lf_d3", bub);
        chk("lf_halt", 64'(halted), 64'd1);

        // asynchronous reset in the middle of a drain
        do_reset();
        drv(16'hF000, 1);
        cyc("mr_hlt", mk(9'h100,3'd0,4'h0,4'h0,4'h0,3'd0,16'h0000));
        drv(16'h0, 0);
        cyc("mr_d1", bub);
        rst_n = 0;
        #1 chk_zero("mr_async");
        step();
        chk_zero("mr_held");
        @(negedge clk);
        rst_n = 1;
        step();
        cyc("mr_idle", bub);
        chk("mr_run", 64'({stall_fetch, halted}), 64'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised pipelined successor to the single-cycle control decoder.
- Decodes the 16-bit ISA (16 opcodes) and registers the result into an ID/EX pipeline register.
- Adds a valid/stall/flush handshake, load-use hazard detection with bubble insertion, and a halt drain state machine.
- Sits between the fetch stage (IF/ID) and the execute stage of the pipelined CPU.

Parameters:
- DATA_W, 16, immediate output width. Must be ≥16. All extensions go to DATA_W.
- REG_AW, 4, register address width. Register fields are taken from the instruction and zero-extended to REG_AW.
- DRAIN_CYCLES, 3, number of cycles after HLT is captured before `halted` asserts. Legal range 1..15.
- RED_EN, 1, RED decode selector.
  - 1: RED decodes as an R-type with RegWrite.
  - 0: RED decodes as a NOP with valid=1.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_in  in  16  instruction from IF/ID
- instr_valid  in  1  instr_in holds a real instruction
- flush  in  1  branch taken in EX; squashes the instruction in ID and the one entering it
- ex_stall  in  1  EX cannot accept; hold the ID register
- id_valid  out  1  ID register holds a live instruction
- id_ctrl  out  9  control bits:
  - [0] RegWrite, [1] ALUsrc, [2] MemWrite, [3] MemToReg, [4] MemRead
  - [5] Branch, [6] BranchRegister, [7] PCS, [8] HLT
- id_alu_op  out  3  opcode[2:0] for opcodes 0–7; 000 otherwise
- id_rd, id_rs, id_rt  out  REG_AW  register addresses; 0 when unused
- id_cond  out  3  instr[11:9]
- id_imm  out  DATA_W  decoded immediate
- stall_fetch  out  1  IF must hold the current instruction (combinational)
- halted  out  1  core halted; sticky until reset

Behaviour:
- Reset (async, rst_n=0): all registered outputs go to 0, FSM=RUN, drain counter=0. Reset asserted mid-drain aborts the drain.
- Decode is combinational from instr_in. It is captured on the clock edge, so outputs have 1-cycle latency.
- Per-opcode control, fields and immediate:
  - ADD/SUB/XOR/PADDSB (and RED when RED_EN=1): RegWrite; rd=[11:8], rs=[7:4], rt=[3:0]; imm=0.
  - instr==0x0000: NOP. ctrl=0, id_valid=1.
  - SLL/SRA/ROR: RegWrite|ALUsrc; rd, rs; imm=zero-extended [3:0].
  - LW: RegWrite|ALUsrc|MemToReg|MemRead; rd, rs; imm=sign-extended [3:0].
  - SW: ALUsrc|MemWrite; rs=[7:4], rt=[11:8]; imm=sign-extended [3:0].
  - LHB: RegWrite|ALUsrc; rd=rs=[11:8]; imm=zero-extended [7:0].
  - LLB: RegWrite|ALUsrc; rd; imm=zero-extended [7:0].
  - B: Branch; imm=sign-extended {[8:0],1'b0}.
  - BR: Branch|BranchRegister; rs=[7:4].
  - PCS: RegWrite|ALUsrc|PCS; rd.
  - HLT: HLT bit only.
- Register-read usage (for hazard checks):
  - rs is read by R-types, shifts, LW, SW, BR, LHB.
  - rt is read by R-types and SW.
- Load-use hazard: asserts when all of the following hold:
  - id_valid=1 and id_ctrl[4]=1 (LW in ID);
  - id_rd≠0;
  - instr_valid=1 and the incoming instruction reads a register equal to id_rd.
- When the hazard asserts: stall_fetch=1, and on the next edge the ID register is loaded with a bubble (id_valid=0, all fields 0). Exactly one bubble per hazard.
- Priority on each edge: flush > ex_stall > hazard > normal load.
  - flush: ID register is cleared to a bubble, including when ex_stall=1.
  - ex_stall (no flush): ID register holds its value; stall_fetch=1.
  - normal: the ID register loads the decode when instr_valid=1, otherwise a bubble.
- Halt FSM: RUN → DRAIN → HALTED.
  - RUN→DRAIN: on the edge that captures a valid, unflushed HLT. Counter loads DRAIN_CYCLES.
  - DRAIN:
    - stall_fetch=1; only bubbles are loaded.
    - Counter decrements every edge unless ex_stall=1.
    - When the counter reaches 0 → HALTED.
    - If flush=1 while the HLT is still in the ID register (counter==DRAIN_CYCLES), the HLT is squashed and the FSM returns to RUN.
    - flush at any later point in DRAIN is ignored by the FSM.
  - HALTED: halted=1, stall_fetch=1, bubbles only, until reset.
- `halted` is registered. It rises exactly DRAIN_CYCLES edges after the capture edge, with no ex_stall during that time.
- Counter wrap-around is impossible; the counter saturates at 0.

Test Plan:
- Reset: rst_n=0 mid-drain → next cycle halted=0, id_valid=0, stall_fetch=0, all outputs 0.
- ADD decode: instr 0x0123 valid → next edge id_valid=1, id_ctrl=0x001, rd=1, rs=2, rt=3, id_imm=0. NOP 0x0000 → id_ctrl=0x000, id_valid=1.
- LW decode and load-use: LW 0x845F → id_ctrl=0x01B, rd=4, rs=5, id_imm=0xFFFF. Then ADD 0x0647 → stall_fetch=1 for one cycle, one bubble, then ADD issues with rs=4, rt=7. Repeat with rd=0 → no stall.
- B decode: 0xC5FF → id_cond=3'b010, id_ctrl=0x020, id_imm=0xFFFE. SW 0x9A37 → rt=0xA, rs=3, id_imm=0x0007, id_ctrl=0x006.
- Halt drain (DRAIN_CYCLES=3): HLT 0xF000 captured at edge N → stall_fetch=1 from N, halted=1 at edge N+3. Adding ex_stall for 2 cycles during drain → halted at edge N+5.
- Flush vs. halt and stall: flush=1 while HLT is in ID → next edge id_valid=0, FSM RUN, stall_fetch=0. Simultaneous flush and ex_stall with ADD in ID → bubble loaded.
